// File: rtl/vmem_wr_scheduler.sv
// Sequences every write into the VGA text memory: a CPU write FIFO drained one
// entry at a time, plus a clear engine that fills the whole screen with one character.
module vmem_wr_scheduler #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WEN_CYCLES = 2,
  parameter int unsigned CLR_COUNT  = 10240
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic [7:0]               cpu_char,
  output logic                     cpu_stall,
  input  logic                     clr_req,
  input  logic [7:0]               clr_char,
  output logic                     clr_busy,
  output logic [ADDR_WIDTH-1:0]    vga_addr,
  output logic [7:0]               vga_char,
  output logic                     vga_wen,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = (WEN_CYCLES > 1) ? $clog2(WEN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH+7:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic [7:0]            clr_char_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  cnt_last;
  logic                  clr_last;

  // Space freed by a pop is only visible to the next cycle's push.
  always_comb begin
    full      = (fifo_level == LW'(DEPTH));
    empty     = (fifo_level == '0);
    push      = cpu_wr_en & ~full & ~clr_busy;
    cpu_stall = cpu_wr_en & (full | clr_busy);
    pop       = (state == IDLE) & ~empty;
    cnt_last  = (cnt == CW'(WEN_CYCLES - 1));
    clr_last  = (vga_addr == ADDR_WIDTH'(CLR_COUNT - 1));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_char};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cnt        <= '0;
      clr_busy   <= 1'b0;
      clr_char_q <= '0;
      vga_addr   <= '0;
      vga_char   <= '0;
      vga_wen    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase

      if (clr_req && !clr_busy) begin
        clr_busy   <= 1'b1;
        clr_char_q <= clr_char;
      end

      case (state)
        IDLE: begin
          vga_wen <= 1'b0;
          if (clr_busy && empty) begin
            vga_addr <= '0;
            vga_char <= clr_char_q;
            cnt      <= '0;
            state    <= CLEAR;
          end else if (!empty) begin
            {vga_addr, vga_char} <= mem[rd_ptr];
            state                <= SETUP;
          end
        end
        SETUP: begin
          vga_wen <= 1'b1;
          cnt     <= '0;
          state   <= WRITE;
        end
        WRITE: begin
          if (cnt_last) begin
            vga_wen <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEAR: begin
          // First CLEAR cycle is the address setup; afterwards wen stays high
          // and the address steps every WEN_CYCLES cycles.
          if (!vga_wen) begin
            vga_wen <= 1'b1;
            cnt     <= '0;
          end else if (cnt_last) begin
            if (clr_last) begin
              vga_wen  <= 1'b0;
              clr_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              vga_addr <= vga_addr + 1'b1;
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
